// File: rtl/dps_decoder_29.sv
// -----------------------------------------------------------------------------
// dps_decoder_29
// Receive-side decoder for the 29-wire DPS (Fibonacci-numeral crosstalk
// avoidance) bus. It rebuilds the binary data word as the weighted sum of the
// set codeword bits. Three pipeline stages with valid/ready flow control:
//   S1: capture codeword + valid
//   S2: three partial sums (bits 0..9, 10..19, 20..28)
//   S3: final sum -> dataout, out_valid
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   codein     in   29-bit codeword (bit-aligned with the encoder's codeout)
//   in_valid   in   codein is valid this cycle
//   in_ready   out  decoder accepts codein this cycle (combinational)
//   dataout    out  decoded data word (`DBLEN29 bits), defined when out_valid
//   out_valid  out  dataout is valid
//   out_ready  in   downstream accepts dataout
//   code_err   out  forbidden-pattern flag aligned with dataout
//                   (only when DPS_DEC_CHECK_EN is defined)
//
// Configuration macro: DPS_DEC_CHECK_EN enables the forbidden-pattern checker
// and the code_err port. Without it no check logic exists.
// -----------------------------------------------------------------------------

// Data width: wide enough that even the heaviest 29-bit pattern
// (sum of all weights = 1664079) is represented without wrap-around.
`ifndef DBLEN29
`define DBLEN29 21
`endif

module dps_decoder_29 (
   input  logic                clock,
   input  logic                reset,
   input  logic [28:0]         codein,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [`DBLEN29-1:0] dataout,
   output logic                out_valid,
`ifdef DPS_DEC_CHECK_EN
   input  logic                out_ready,
   output logic                code_err
`else
   input  logic                out_ready
`endif
);

   localparam int unsigned DW = `DBLEN29;
   localparam int unsigned CW = 29;

   // Fibonacci numbers FNS01..FNS29
   localparam int unsigned FNS01 = 1;
   localparam int unsigned FNS02 = 1;
   localparam int unsigned FNS03 = 2;
   localparam int unsigned FNS04 = 3;
   localparam int unsigned FNS05 = 5;
   localparam int unsigned FNS06 = 8;
   localparam int unsigned FNS07 = 13;
   localparam int unsigned FNS08 = 21;
   localparam int unsigned FNS09 = 34;
   localparam int unsigned FNS10 = 55;
   localparam int unsigned FNS11 = 89;
   localparam int unsigned FNS12 = 144;
   localparam int unsigned FNS13 = 233;
   localparam int unsigned FNS14 = 377;
   localparam int unsigned FNS15 = 610;
   localparam int unsigned FNS16 = 987;
   localparam int unsigned FNS17 = 1597;
   localparam int unsigned FNS18 = 2584;
   localparam int unsigned FNS19 = 4181;
   localparam int unsigned FNS20 = 6765;
   localparam int unsigned FNS21 = 10946;
   localparam int unsigned FNS22 = 17711;
   localparam int unsigned FNS23 = 28657;
   localparam int unsigned FNS24 = 46368;
   localparam int unsigned FNS25 = 75025;
   localparam int unsigned FNS26 = 121393;
   localparam int unsigned FNS27 = 196418;
   localparam int unsigned FNS28 = 317811;
   localparam int unsigned FNS29 = 514229;

   // Bit weights: w0=1, wk=FNS(k+1) for k=1..26, w27=2*FNS28, w28=FNS29.
   // The top two wires carry the encoder's split MSB weights.
   localparam logic [DW-1:0] WEIGHT [CW] = '{
      DW'(FNS01),                                         // bit 0
      DW'(FNS02), DW'(FNS03), DW'(FNS04), DW'(FNS05),     // bits 1..4
      DW'(FNS06), DW'(FNS07), DW'(FNS08), DW'(FNS09),     // bits 5..8
      DW'(FNS10), DW'(FNS11), DW'(FNS12), DW'(FNS13),     // bits 9..12
      DW'(FNS14), DW'(FNS15), DW'(FNS16), DW'(FNS17),     // bits 13..16
      DW'(FNS18), DW'(FNS19), DW'(FNS20), DW'(FNS21),     // bits 17..20
      DW'(FNS22), DW'(FNS23), DW'(FNS24), DW'(FNS25),     // bits 21..24
      DW'(FNS26), DW'(FNS27),                             // bits 25..26
      DW'(2 * FNS28),                                     // bit 27
      DW'(FNS29)                                          // bit 28
   };

   // Pipeline state
   logic          s1_valid;
   logic [CW-1:0] s1_code;
   logic          s2_valid;
   logic [DW-1:0] s2_pa;
   logic [DW-1:0] s2_pb;
   logic [DW-1:0] s2_pc;

   // Next-state values for S2
   logic [DW-1:0] pa_next;
   logic [DW-1:0] pb_next;
   logic [DW-1:0] pc_next;

   logic          advance;

   // Whole pipeline freezes only while a valid output is being refused
   assign advance  = ~(out_valid & ~out_ready);
   assign in_ready = advance;

   // S2 partial sums over three codeword slices
   always_comb begin
      pa_next = '0;
      pb_next = '0;
      pc_next = '0;
      for (int i = 0; i < 10; i++) begin
         if (s1_code[i]) pa_next = pa_next + WEIGHT[i];
      end
      for (int i = 10; i < 20; i++) begin
         if (s1_code[i]) pb_next = pb_next + WEIGHT[i];
      end
      for (int i = 20; i < 29; i++) begin
         if (s1_code[i]) pc_next = pc_next + WEIGHT[i];
      end
   end

   // S1: capture codeword and valid
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_code  <= codein;
      end
   end

   // S2: partial sums
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_pa    <= '0;
         s2_pb    <= '0;
         s2_pc    <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_pa    <= pa_next;
         s2_pb    <= pb_next;
         s2_pc    <= pc_next;
      end
   end

   // S3: final sum and output valid
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         dataout   <= '0;
      end else if (advance) begin
         out_valid <= s2_valid;
         dataout   <= s2_pa + s2_pb + s2_pc;
      end
   end

`ifdef DPS_DEC_CHECK_EN
   // An interior wire that differs from both neighbours forms an isolated
   // "010" or "101", which a legal DPS codeword never contains.
   function automatic logic forbidden(input logic [CW-1:0] c);
      logic err;
      err = 1'b0;
      for (int k = 1; k <= 26; k++) begin
         if ((c[k] != c[k-1]) && (c[k] != c[k+1])) err = 1'b1;
      end
      return err;
   endfunction

   logic s1_err;
   logic s2_err;
   logic err_next;

   always_comb begin
      err_next = 1'b0;
      err_next = forbidden(codein);
   end

   // Flag travels with its word and holds on stall like the data
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_err   <= 1'b0;
         s2_err   <= 1'b0;
         code_err <= 1'b0;
      end else if (advance) begin
         s1_err   <= err_next;
         s2_err   <= s1_err;
         code_err <= s2_err;
      end
   end
`endif

endmodule

// File: tb/tb_dps_decoder_29.sv
`ifndef DBLEN29
`define DBLEN29 21
`endif

module tb_dps_decoder_29;

   localparam int unsigned DW = `DBLEN29;

   logic          clock;
   logic          reset;
   logic [28:0]   codein;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dataout;
   logic          out_valid;
   logic          out_ready;
`ifdef DPS_DEC_CHECK_EN
   logic          code_err;
`endif

   dps_decoder_29 dut (
      .clock     (clock),
      .reset     (reset),
      .codein    (codein),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dataout   (dataout),
      .out_valid (out_valid),
`ifdef DPS_DEC_CHECK_EN
      .out_ready (out_ready),
      .code_err  (code_err)
`else
      .out_ready (out_ready)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [28:0]   code;
      logic [DW-1:0] data;
      logic          err;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int unsigned   acc;
   } sb_t;

   vec_t        vecs [12];
   sb_t         sb [$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned step_no = 0;
   logic        lat_check = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Independent weight model
   function automatic int unsigned fib(input int unsigned n);
      int unsigned a, b, t;
      a = 1; b = 1;
      for (int i = 3; i <= int'(n); i++) begin
         t = a + b; a = b; b = t;
      end
      return b;
   endfunction

   function automatic int unsigned tb_weight(input int unsigned k);
      if (k == 0)  return 1;
      if (k <= 26) return fib(k + 1);
      if (k == 27) return 2 * fib(28);
      return fib(29);
   endfunction

   // Greedy encoder: weights form a complete sequence, so greedy in
   // descending-weight order reaches zero for any value up to the total.
   function automatic logic [28:0] encode(input int unsigned d);
      logic [28:0] c;
      int unsigned rem;
      c = '0; rem = d;
      if (rem >= tb_weight(27)) begin c[27] = 1'b1; rem -= tb_weight(27); end
      if (rem >= tb_weight(28)) begin c[28] = 1'b1; rem -= tb_weight(28); end
      for (int k = 26; k >= 0; k--) begin
         if (rem >= tb_weight(k)) begin c[k] = 1'b1; rem -= tb_weight(k); end
      end
      return c;
   endfunction

   function automatic logic fpf(input logic [28:0] c);
      logic e;
      e = 1'b0;
      for (int k = 1; k <= 26; k++)
         if ((c[k] != c[k-1]) && (c[k] != c[k+1])) e = 1'b1;
      return e;
   endfunction

   // One cycle: drive at negedge, score both handshakes, advance to next negedge
   task automatic step(input logic v, input logic [28:0] c, input logic ordy,
                       input logic [DW-1:0] exp_data, input logic exp_err);
      sb_t s, e;
      in_valid  = v;
      codein    = c;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'(0));
         end else begin
            s = sb.pop_front();
            chk("dataout", 64'(dataout), 64'(s.data));
            if (lat_check) chk("latency", 64'(step_no - s.acc), 64'(3));
`ifdef DPS_DEC_CHECK_EN
            chk("code_err", 64'(code_err), 64'(s.err));
`endif
         end
      end
      if (in_valid && in_ready) begin
         e.data = exp_data; e.err = exp_err; e.acc = step_no;
         sb.push_back(e);
      end
      @(negedge clock);
      step_no++;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) step(1'b0, '0, 1'b1, '0, 1'b0);
      chk("drain_empty", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [28:0]   c;
      int unsigned   d;
      int unsigned   sent;
      logic [DW-1:0] held;
      logic          pat [11];

      vecs[0]  = '{29'h0000000, DW'(0),       1'b0};
      vecs[1]  = '{29'h0000001, DW'(1),       1'b0};
      vecs[2]  = '{29'h0000002, DW'(1),       1'b1};
      vecs[3]  = '{29'h0000003, DW'(2),       1'b0};
      vecs[4]  = '{29'h0000004, DW'(2),       1'b1};
      vecs[5]  = '{29'h0000006, DW'(3),       1'b0};
      vecs[6]  = '{29'h0000400, DW'(89),      1'b1};
      vecs[7]  = '{29'h0080000, DW'(6765),    1'b1};
      vecs[8]  = '{29'h0100000, DW'(10946),   1'b1};
      vecs[9]  = '{29'h8000000, DW'(635622),  1'b0};
      vecs[10] = '{29'h10000000, DW'(514229), 1'b0};
      vecs[11] = '{29'h1FFFFFFF, DW'(1664079), 1'b0};

      reset = 1'b1; in_valid = 1'b0; codein = '0; out_ready = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_dataout", 64'(dataout), 64'(0));
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clock);

      // Table vectors, one per cycle, exact 3-cycle latency
      lat_check = 1'b1;
      for (int i = 0; i < 12; i++) step(1'b1, vecs[i].code, 1'b1, vecs[i].data, vecs[i].err);
      drain();

      // Round trip through the encoder model
      for (int i = 0; i < 12; i++) begin
         case (i)
            0: d = 0;
            1: d = 1;
            2: d = 1000;
            3: d = 832039;
            default: d = $urandom_range(0, 832039);
         endcase
         c = encode(d);
         step(1'b1, c, 1'b1, DW'(d), fpf(c));
      end
      drain();

      // Bubbles: out_valid follows in_valid three cycles later
      for (int n = 0; n < 11; n++) pat[n] = (n < 8) && (n % 2 == 0);
      for (int n = 0; n < 11; n++) begin
         chk("bubble_valid", 64'(out_valid), (n >= 3) ? 64'(pat[n-3]) : 64'(0));
         step(pat[n], vecs[n].code, 1'b1, vecs[n].data, vecs[n].err);
      end
      drain();

      // Backpressure: 10 words, out_ready low for 4 cycles mid-stream
      lat_check = 1'b0;
      sent = 0;
      held = '0;
      for (int i = 0; i < 40 && sent < 10; i++) begin
         logic ordy;
         ordy = !(i >= 5 && i < 9);
         d = $urandom_range(0, 832039);
         c = encode(d);
         out_ready = ordy;
         #1;
         if (i == 5) begin
            chk("stall_pre_valid", 64'(out_valid), 64'(1));
            held = dataout;
         end
         if (!ordy && out_valid) begin
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_hold", 64'(dataout), 64'(held));
         end
         if (in_ready) sent++;
         step(1'b1, c, ordy, DW'(d), fpf(c));
      end
      chk("bp_sent", 64'(sent), 64'(10));
      drain();

      // Reset with three words in flight
      for (int i = 0; i < 3; i++) step(1'b1, vecs[9+i].code, 1'b0, vecs[9+i].data, vecs[9+i].err);
      // out_ready low above only matters once out_valid rises; nothing popped
      chk("pre_reset_valid", 64'(out_valid), 64'(1));
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_dataout", 64'(dataout), 64'(0));
      sb.delete();
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_idle", 64'(out_valid), 64'(0));
         step(1'b0, '0, 1'b1, '0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
